// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request port and byte-bus signals of mem_ctrl.
// master = requester plus memory responder; slave = the controller.
interface mem_ctrl_if;
  logic        I_enable;
  logic [1:0]  I_memory_mode;
  logic [1:0]  I_memory_size;
  logic [15:0] I_addr;
  logic [15:0] I_data;
  logic [15:0] O_data;
  logic        O_busy;
  logic        O_done;
  logic        O_error;
  logic        O_mem_req;
  logic        O_mem_we;
  logic [15:0] O_mem_addr;
  logic [7:0]  O_mem_wdata;
  logic [7:0]  I_mem_rdata;
  logic        I_mem_ack;

  modport master (
    output I_enable,
    output I_memory_mode,
    output I_memory_size,
    output I_addr,
    output I_data,
    output I_mem_rdata,
    output I_mem_ack,
    input  O_data,
    input  O_busy,
    input  O_done,
    input  O_error,
    input  O_mem_req,
    input  O_mem_we,
    input  O_mem_addr,
    input  O_mem_wdata
  );

  modport slave (
    input  I_enable,
    input  I_memory_mode,
    input  I_memory_size,
    input  I_addr,
    input  I_data,
    input  I_mem_rdata,
    input  I_mem_ack,
    output O_data,
    output O_busy,
    output O_done,
    output O_error,
    output O_mem_req,
    output O_mem_we,
    output O_mem_addr,
    output O_mem_wdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: 1/2-byte little-endian access over a byte bus.
// Define MEM_CTRL_TIMEOUT_EN to enable the 8-bit ack watchdog.
module mem_ctrl (
  input  logic      I_clk,
  input  logic      I_reset_n,
  mem_ctrl_if.slave bus
);
  localparam logic [1:0] MEM_NOP   = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BYTE0 = 2'd1;
  localparam logic [1:0] S_BYTE1 = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic [15:0] rdata_q;
  logic [7:0]  lo_q;
  logic        write_q;
  logic        wide_q;
  logic        err_q;
  logic        start;
  logic        legal;
  logic        req;
  logic        ack;
  logic        timeout;

  assign start = bus.I_enable &&
                 (bus.I_memory_mode == MEM_READ ||
                  bus.I_memory_mode == MEM_WRITE);
  assign legal = bus.I_memory_size == 2'd1 ||
                 bus.I_memory_size == 2'd2;
  assign req   = state_q == S_BYTE0 ||
                 state_q == S_BYTE1;
  assign ack   = req && bus.I_mem_ack;

`ifdef MEM_CTRL_TIMEOUT_EN
  logic [7:0] wd_q;

  // 255th edge without ack is when the count reads 254
  assign timeout = req && !bus.I_mem_ack &&
                   wd_q == 8'd254;

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      wd_q <= 8'd0;
    end else if (!req || ack) begin
      wd_q <= 8'd0;
    end else begin
      wd_q <= wd_q + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = legal ? S_BYTE0 : S_DONE;
        end
      end
      S_BYTE0: begin
        if (timeout) begin
          state_d = S_DONE;
        end else if (ack) begin
          state_d = wide_q ? S_BYTE1 : S_DONE;
        end
      end
      S_BYTE1: begin
        if (timeout || ack) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= 16'd0;
      data_q  <= 16'd0;
      write_q <= 1'b0;
      wide_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        addr_q  <= bus.I_addr;
        data_q  <= bus.I_data;
        write_q <= bus.I_memory_mode == MEM_WRITE;
        wide_q  <= bus.I_memory_size == 2'd2;
        err_q   <= !legal;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  // O_data only changes on the edge that enters DONE
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      lo_q    <= 8'd0;
      rdata_q <= 16'd0;
    end else if (ack && !write_q) begin
      if (state_q == S_BYTE1) begin
        rdata_q <= {bus.I_mem_rdata, lo_q};
      end else if (wide_q) begin
        lo_q <= bus.I_mem_rdata;
      end else begin
        rdata_q <= {8'h00, bus.I_mem_rdata};
      end
    end
  end

  assign bus.O_data      = rdata_q;
  assign bus.O_busy      = req;
  assign bus.O_done      = state_q == S_DONE;
  assign bus.O_error     = state_q == S_DONE && err_q;
  assign bus.O_mem_req   = req;
  assign bus.O_mem_we    = req && write_q;
  assign bus.O_mem_addr  = (state_q == S_BYTE1) ?
                           addr_q + 16'd1 : addr_q;
  assign bus.O_mem_wdata = (state_q == S_BYTE1) ?
                           data_q[15:8] : data_q[7:0];
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl with a
// delayed-ack byte memory responder.
module tb_mem_ctrl;
  localparam logic [1:0] MEM_NOP   = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } bus_t;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          cyc;
    int          lat;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ack_dly = 0;
  bit   hold_ack = 1'b0;
  bit   stray_ack = 1'b0;
  logic [15:0] last_data = 16'd0;
  bus_t bq[$];
  res_t rq[$];

  mem_ctrl_if bus();

  mem_ctrl dut (
    .I_clk    (clk),
    .I_reset_n(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(
      input logic [15:0] a);
    return a[7:0] ^ 8'h91;
  endfunction

  initial begin : responder
    int wc;
    wc = 0;
    bus.I_mem_ack = 1'b0;
    bus.I_mem_rdata = 8'd0;
    forever begin
      @(negedge clk);
      bus.I_mem_ack = 1'b0;
      if (!bus.O_mem_req) begin
        wc = 0;
        if (stray_ack) bus.I_mem_ack = 1'b1;
      end else if (bq.size() == 0) begin
        check("unexp_req", 32'(bus.O_mem_req), 32'd0);
      end else begin
        check("mem_addr", 32'(bus.O_mem_addr),
              32'(bq[0].addr));
        check("mem_we", 32'(bus.O_mem_we),
              32'(bq[0].we));
        if (bq[0].we)
          check("mem_wdata", 32'(bus.O_mem_wdata),
                32'(bq[0].wdata));
        if (!hold_ack && wc >= ack_dly) begin
          bus.I_mem_rdata = rd_byte(bq[0].addr);
          bus.I_mem_ack = 1'b1;
          wc = 0;
          void'(bq.pop_front());
        end else begin
          wc++;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.O_done) begin
        if (rq.size() == 0) begin
          check("unexp_done", 32'(bus.O_done), 32'd0);
        end else begin
          res_t r;
          r = rq.pop_front();
          check("o_data", 32'(bus.O_data), 32'(r.data));
          check("o_error", 32'(bus.O_error), 32'(r.err));
          check("busy_in_done", 32'(bus.O_busy), 32'd0);
          check("req_in_done", 32'(bus.O_mem_req), 32'd0);
          if (r.lat >= 0)
            check("latency", 32'(cyc - r.cyc), 32'(r.lat));
        end
      end
    end
  end

  // Caller is at a falling edge; drives one request cycle.
  task automatic issue(input logic [1:0] mode,
                       input logic [1:0] size,
                       input logic [15:0] a,
                       input logic [15:0] d,
                       input bit tmo);
    res_t r;
    bus_t e;
    int   nb;
    int   np;
    bus.I_enable = 1'b1;
    bus.I_memory_mode = mode;
    bus.I_memory_size = size;
    bus.I_addr = a;
    bus.I_data = d;
    if (mode != MEM_NOP) begin
      nb = (size == 2'd1) ? 1 : (size == 2'd2) ? 2 : 0;
      r.cyc = cyc;
      r.err = (nb == 0) || tmo;
      r.data = last_data;
      if (nb == 0) r.lat = 1;
      else if (tmo) r.lat = 256;
      else if (hold_ack) r.lat = -1;
      else r.lat = 1 + nb * (1 + ack_dly);
      if (mode == MEM_READ && !tmo) begin
        if (nb == 1) r.data = {8'h00, rd_byte(a)};
        if (nb == 2)
          r.data = {rd_byte(a + 16'd1), rd_byte(a)};
      end
      last_data = r.data;
      rq.push_back(r);
      np = tmo ? 1 : nb;
      for (int b = 0; b < np; b++) begin
        e.addr = a + 16'(b);
        e.we = (mode == MEM_WRITE);
        e.wdata = (b == 0) ? d[7:0] : d[15:8];
        bq.push_back(e);
      end
    end
    @(negedge clk);
    bus.I_enable = 1'b0;
    bus.I_memory_mode = MEM_NOP;
  endtask

  task automatic wait_done(input int limit,
                           input bit chk_bus);
    for (int i = 0; i < limit && rq.size() != 0; i++)
      @(negedge clk);
    check("drain", 32'(rq.size()), 32'd0);
    if (chk_bus) check("bus_drain", 32'(bq.size()), 32'd0);
    rq.delete();
    @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin : stim
    logic [1:0]  m;
    logic [1:0]  s;
    bus.I_enable = 1'b0;
    bus.I_memory_mode = MEM_NOP;
    bus.I_memory_size = 2'd0;
    bus.I_addr = 16'd0;
    bus.I_data = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.O_busy), 32'd0);
    check("rst_done", 32'(bus.O_done), 32'd0);
    check("rst_error", 32'(bus.O_error), 32'd0);
    check("rst_data", 32'(bus.O_data), 32'd0);
    check("rst_req", 32'(bus.O_mem_req), 32'd0);
    check("rst_we", 32'(bus.O_mem_we), 32'd0);
    check("rst_addr", 32'(bus.O_mem_addr), 32'd0);
    check("rst_wdata", 32'(bus.O_mem_wdata), 32'd0);
    rst_n = 1'b1;

    issue(MEM_READ, 2'd1, 16'h1234, 16'h0000, 1'b0);
    wait_done(50, 1'b1);
    check("rd1_hold", 32'(bus.O_data), 32'h00A5);

    issue(MEM_WRITE, 2'd2, 16'hFFFF, 16'hBEEF, 1'b0);
    wait_done(50, 1'b1);
    check("wr_keeps", 32'(bus.O_data), 32'h00A5);

    ack_dly = 5;
    issue(MEM_READ, 2'd2, 16'h2001, 16'h0000, 1'b0);
    repeat (3) begin
      @(negedge clk);
      bus.I_enable = 1'b1;
      bus.I_memory_mode = MEM_WRITE;
      bus.I_memory_size = 2'd1;
      bus.I_addr = 16'h5555;
      @(negedge clk);
      bus.I_enable = 1'b0;
      bus.I_memory_mode = MEM_NOP;
    end
    wait_done(100, 1'b1);
    check("rd2_slow", 32'(bus.O_data), 32'h9390);
    ack_dly = 0;

    issue(MEM_READ, 2'd3, 16'h3000, 16'h0000, 1'b0);
    wait_done(20, 1'b1);
    issue(MEM_WRITE, 2'd0, 16'h3001, 16'h1111, 1'b0);
    wait_done(20, 1'b1);
    check("ill_keeps", 32'(bus.O_data), 32'h9390);

    issue(MEM_NOP, 2'd1, 16'h4000, 16'h0000, 1'b0);
    check("nop_busy", 32'(bus.O_busy), 32'd0);
    repeat (3) @(negedge clk);
    check("nop_req", 32'(bus.O_mem_req), 32'd0);

    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    check("stray_busy", 32'(bus.O_busy), 32'd0);
    check("stray_data", 32'(bus.O_data), 32'h9390);

    for (int i = 0; i < 12; i++) begin
      ack_dly = $urandom_range(0, 3);
      m = ($urandom_range(0, 1) == 1) ? MEM_READ : MEM_WRITE;
      s = 2'($urandom_range(1, 2));
      issue(m, s, 16'($urandom), 16'($urandom), 1'b0);
      wait_done(100, 1'b1);
    end

    ack_dly = 3;
    issue(MEM_READ, 2'd2, 16'h4080, 16'h0000, 1'b0);
    for (int i = 0; i < 50 && bq.size() != 1; i++)
      @(negedge clk);
    @(posedge clk);
    #2;
    check("b1_req", 32'(bus.O_mem_req), 32'd1);
    check("b1_addr", 32'(bus.O_mem_addr), 32'h4081);
    rst_n = 1'b0;
    #1;
    check("arst_req", 32'(bus.O_mem_req), 32'd0);
    check("arst_busy", 32'(bus.O_busy), 32'd0);
    check("arst_data", 32'(bus.O_data), 32'd0);
    rq.delete();
    bq.delete();
    last_data = 16'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ack_dly = 0;
    issue(MEM_READ, 2'd2, 16'h0F0E, 16'h0000, 1'b0);
    wait_done(50, 1'b1);

`ifdef MEM_CTRL_TIMEOUT_EN
    hold_ack = 1'b1;
    issue(MEM_READ, 2'd1, 16'h7777, 16'h0000, 1'b1);
    wait_done(400, 1'b0);
    bq.delete();
    hold_ack = 1'b0;
    check("to_req", 32'(bus.O_mem_req), 32'd0);
`else
    hold_ack = 1'b1;
    issue(MEM_READ, 2'd1, 16'h7777, 16'h0000, 1'b0);
    repeat (1010) @(negedge clk);
    check("hold_req", 32'(bus.O_mem_req), 32'd1);
    check("hold_busy", 32'(bus.O_busy), 32'd1);
    hold_ack = 1'b0;
    wait_done(50, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL provide: I_clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL provide: I_reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide: I_enable  input  1  request strobe, sampled only in IDLE.
REQ-004 SHALL provide: I_memory_mode  input  2  MEM_NOP/MEM_READ/MEM_WRITE, using the encodings in mem_acc.vh.
REQ-005 SHALL provide: I_memory_size  input  2  access size in bytes; only 1 or 2 are legal.
REQ-006 SHALL provide: I_addr  input  16  byte address of the access.
REQ-007 SHALL provide: I_data  input  16  write data.
REQ-008 SHALL provide: O_data  output  16  read data, valid while O_done=1.
REQ-009 SHALL provide: O_busy  output  1  high from request accept until the DONE state.
REQ-010 SHALL provide: O_done  output  1  one-cycle completion pulse.
REQ-011 SHALL provide: O_error  output  1  qualifies O_done; high marks a failed or illegal request.
REQ-012 SHALL provide: O_mem_req / O_mem_we  output  1 each  byte-bus request and write enable.
REQ-013 SHALL provide: O_mem_addr  output  16; O_mem_wdata  output  8; I_mem_rdata  input  8; I_mem_ack  input  1  one-cycle byte acknowledge.

Function
REQ-014 SHALL implement the states IDLE, BYTE0, BYTE1 and DONE.
REQ-015 IDLE: on I_enable=1 with mode READ or WRITE, SHALL latch addr/data/mode/size and go to BYTE0 with O_busy=1; mode NOP SHALL be ignored.
REQ-016 Illegal size (0 or 3) SHALL produce no bus activity and go directly to DONE with O_error=1.
REQ-017 BYTE0: O_mem_req=1, O_mem_addr=addr, O_mem_we=(mode==WRITE), O_mem_wdata=data[7:0]; these SHALL stay stable until I_mem_ack is sampled high.
REQ-018 On ack in BYTE0, a read SHALL capture I_mem_rdata into O_data[7:0]; the state SHALL move to BYTE1 if size==2, else to DONE.
REQ-019 BYTE1: O_mem_addr=addr+1 (16-bit wrap, 0xFFFF -> 0x0000), O_mem_wdata=data[15:8]; on ack, a read SHALL capture into O_data[15:8], then go to DONE.
REQ-020 Byte order SHALL be little-endian; a 1-byte read SHALL zero O_data[15:8].
REQ-021 DONE: O_done=1 and O_mem_req=0 for exactly one cycle, then IDLE with O_busy=0.
REQ-022 Latency (ack on first sampling edge): 1-byte access SHALL take 2 cycles accept-to-done; 2-byte SHALL take 3.
REQ-023 I_enable while not in IDLE SHALL be ignored; no request queuing.
REQ-024 I_mem_ack while O_mem_req=0 SHALL be ignored.
REQ-025 O_data SHALL hold its last value outside DONE; for writes it SHALL be unchanged.

Reset
REQ-026 I_reset_n=0 SHALL immediately force IDLE and set O_mem_req=0, O_mem_we=0, O_busy=0, O_done=0, O_error=0, O_data=0, O_mem_addr=0, O_mem_wdata=0, independent of the clock.
REQ-027 Reset mid-transfer SHALL abandon the access with no done pulse; the first request SHALL be accepted on the first rising edge after deassertion.

Configuration
REQ-028 The macro MEM_CTRL_TIMEOUT_EN SHALL control an 8-bit ack watchdog.
REQ-029 With MEM_CTRL_TIMEOUT_EN defined: the counter SHALL clear on each new byte request. If 255 cycles pass in BYTE0/BYTE1 without ack, the block SHALL drop O_mem_req and go to DONE with O_error=1.
REQ-030 Without MEM_CTRL_TIMEOUT_EN: the block SHALL wait indefinitely for ack, and O_error SHALL come only from illegal size.

Verification
REQ-031 Read, size 1, addr 0x1234, rdata 0xA5, ack 1 cycle after req -> one bus cycle at 0x1234, O_we=0; done pulse with O_data=0x00A5, O_error=0.
REQ-032 Write, size 2, addr 0xFFFF, data 0xBEEF -> bytes 0xEF@0xFFFF then 0xBE@0x0000, O_we=1; done after 3 cycles with ack at minimum delay.
REQ-033 Read, size 2, ack delayed 5 cycles per byte -> addr/req stable throughout; O_data={byte1,byte0}; I_enable pulses during the busy period ignored.
REQ-034 Size 3 request -> O_mem_req never asserts; done+error on the next cycle; NOP request -> no state change.
REQ-035 Reset asserted while in BYTE1 -> O_mem_req=0 asynchronously, no done pulse; a new request after release completes normally.
REQ-036 With MEM_CTRL_TIMEOUT_EN defined and ack never given -> done+error 255 cycles after req; without the macro, req stays high beyond 1000 cycles.
